// File: rtl/alarm_controller.sv
`default_nettype none
// ============================================================================
// Module      : alarm_controller
// Description : Alarm clock controller. Holds a user-editable BCD alarm time,
//               compares it with the running BCD time from the system clock,
//               rings a beeping buzzer on the rising edge of a match, and
//               supports timed auto-stop and (optionally) snooze.
//
// Ports       : clk, reset (synchronous, active-low)
//               hour_tens/hour_units/min_tens/min_units : running time (BCD)
//               btn_edit/btn_hour/btn_min/btn_stop/btn_snooze : 1-cycle pulses
//               arm_sw                                  : alarm enable level
//               al_hour_tens/al_hour_units/al_min_tens/al_min_units : alarm
//               editing, ringing, buzzer, armed_led      : status outputs
//
// Config      : `define ALARM_SNOOZE_EN to build the SNOOZED state. Without
//               it, btn_snooze dismisses the alarm exactly like btn_stop.
//
// Revision    : 1.0 - initial release
// ============================================================================
module alarm_controller #(
    parameter int CLK_FREQ   = 100000000,
    parameter int RING_SEC   = 60,
    parameter int SNOOZE_SEC = 300,
    parameter int BEEP_DIV   = 25000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] hour_tens,
    input  logic [3:0] hour_units,
    input  logic [2:0] min_tens,
    input  logic [3:0] min_units,
    input  logic       btn_edit,
    input  logic       btn_hour,
    input  logic       btn_min,
    input  logic       btn_stop,
    input  logic       btn_snooze,
    input  logic       arm_sw,
    output logic [2:0] al_hour_tens,
    output logic [3:0] al_hour_units,
    output logic [2:0] al_min_tens,
    output logic [3:0] al_min_units,
    output logic       editing,
    output logic       ringing,
    output logic       buzzer,
    output logic       armed_led
);

    // ------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------
    localparam logic [2:0] c_S_IDLE    = 3'd0;
    localparam logic [2:0] c_S_EDIT    = 3'd1;
    localparam logic [2:0] c_S_ARMED   = 3'd2;
    localparam logic [2:0] c_S_RINGING = 3'd3;
`ifdef ALARM_SNOOZE_EN
    localparam logic [2:0] c_S_SNOOZED = 3'd4;
`endif

    // ------------------------------------------------------------------
    // Counter sizing. The seconds counter is shared by ring and snooze
    // timeouts, so it is sized for the larger of the two.
    // ------------------------------------------------------------------
    localparam int c_SEC_MAX = (RING_SEC > SNOOZE_SEC) ? RING_SEC : SNOOZE_SEC;
    localparam int c_SEC_W   = $clog2(c_SEC_MAX + 1);
    localparam int c_PRE_W   = (CLK_FREQ > 1) ? $clog2(CLK_FREQ) : 1;
    localparam int c_BEEP_W  = (BEEP_DIV > 1) ? $clog2(BEEP_DIV) : 1;

    localparam logic [c_PRE_W-1:0]  c_PRE_LAST  = c_PRE_W'(CLK_FREQ - 1);
    localparam logic [c_SEC_W-1:0]  c_RING_LAST = c_SEC_W'(RING_SEC - 1);
    localparam logic [c_BEEP_W-1:0] c_BEEP_LAST = c_BEEP_W'(BEEP_DIV - 1);
`ifdef ALARM_SNOOZE_EN
    localparam logic [c_SEC_W-1:0]  c_SNOOZE_LAST = c_SEC_W'(SNOOZE_SEC - 1);
`endif

    // ------------------------------------------------------------------
    // Registers and wires
    // ------------------------------------------------------------------
    logic [2:0]          r_state;
    logic [2:0]          w_next_state;
    logic [2:0]          r_al_hour_tens;
    logic [3:0]          r_al_hour_units;
    logic [2:0]          r_al_min_tens;
    logic [3:0]          r_al_min_units;
    logic                r_match_q;
    logic [c_PRE_W-1:0]  r_pre;
    logic [c_SEC_W-1:0]  r_sec;
    logic [c_BEEP_W-1:0] r_beep_cnt;
    logic                r_buzzer;

    logic w_match;
    logic w_trigger;
    logic w_sec_tick;
    logic w_ring_done;
    logic w_next_timed;
    logic w_state_change;
    logic w_dismiss;

    assign w_match = (hour_tens  == r_al_hour_tens)  &&
                     (hour_units == r_al_hour_units) &&
                     (min_tens   == r_al_min_tens)   &&
                     (min_units  == r_al_min_units);

    // Fire only on the first cycle of the matching minute, so a dismissal
    // inside that minute cannot re-ring.
    assign w_trigger   = w_match & ~r_match_q;
    assign w_sec_tick  = (r_pre == c_PRE_LAST);
    assign w_ring_done = w_sec_tick && (r_sec == c_RING_LAST);
    assign w_state_change = (w_next_state != r_state);

`ifdef ALARM_SNOOZE_EN
    logic w_snooze_done;
    assign w_snooze_done = w_sec_tick && (r_sec == c_SNOOZE_LAST);
    assign w_dismiss     = btn_stop;
    assign w_next_timed  = (w_next_state == c_S_RINGING) ||
                           (w_next_state == c_S_SNOOZED);
`else
    // Without snooze support, the snooze button simply dismisses.
    assign w_dismiss     = btn_stop | btn_snooze;
    assign w_next_timed  = (w_next_state == c_S_RINGING);
`endif

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_S_IDLE: begin
                if (arm_sw)
                    w_next_state = c_S_ARMED;
                else if (btn_edit)
                    w_next_state = c_S_EDIT;
            end
            c_S_EDIT: begin
                if (btn_edit)
                    w_next_state = arm_sw ? c_S_ARMED : c_S_IDLE;
            end
            c_S_ARMED: begin
                if (!arm_sw)
                    w_next_state = c_S_IDLE;
                else if (btn_edit)
                    w_next_state = c_S_EDIT;
                else if (w_trigger)
                    w_next_state = c_S_RINGING;
            end
            c_S_RINGING: begin
                if (w_dismiss)
                    w_next_state = c_S_ARMED;
`ifdef ALARM_SNOOZE_EN
                else if (btn_snooze)
                    w_next_state = c_S_SNOOZED;
`endif
                else if (!arm_sw)
                    w_next_state = c_S_IDLE;
                else if (w_ring_done)
                    w_next_state = c_S_ARMED;
            end
`ifdef ALARM_SNOOZE_EN
            c_S_SNOOZED: begin
                if (btn_stop)
                    w_next_state = c_S_ARMED;
                else if (!arm_sw)
                    w_next_state = c_S_IDLE;
                else if (w_snooze_done)
                    w_next_state = c_S_RINGING;
            end
`endif
            default: w_next_state = c_S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state   <= c_S_IDLE;
            r_match_q <= 1'b0;
        end else begin
            r_state   <= w_next_state;
            r_match_q <= w_match;
        end
    end

    // ------------------------------------------------------------------
    // Alarm time editing (BCD, hour and minute wrap independently)
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_al_hour_tens  <= 3'd0;
            r_al_hour_units <= 4'd0;
            r_al_min_tens   <= 3'd0;
            r_al_min_units  <= 4'd0;
        end else if (r_state == c_S_EDIT) begin
            if (btn_hour) begin
                if ((r_al_hour_tens == 3'd2) && (r_al_hour_units == 4'd3)) begin
                    r_al_hour_tens  <= 3'd0;
                    r_al_hour_units <= 4'd0;
                end else if (r_al_hour_units == 4'd9) begin
                    r_al_hour_tens  <= r_al_hour_tens + 3'd1;
                    r_al_hour_units <= 4'd0;
                end else begin
                    r_al_hour_units <= r_al_hour_units + 4'd1;
                end
            end
            if (btn_min) begin
                if (r_al_min_units == 4'd9) begin
                    r_al_min_units <= 4'd0;
                    r_al_min_tens  <= (r_al_min_tens == 3'd5) ? 3'd0
                                                               : r_al_min_tens + 3'd1;
                end else begin
                    r_al_min_units <= r_al_min_units + 4'd1;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Prescaler and seconds counter: run only while staying in a timed
    // state, restart from zero on every entry to one.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_pre <= '0;
            r_sec <= '0;
        end else if (!w_next_timed || w_state_change) begin
            r_pre <= '0;
            r_sec <= '0;
        end else if (w_sec_tick) begin
            r_pre <= '0;
            r_sec <= r_sec + c_SEC_W'(1);
        end else begin
            r_pre <= r_pre + c_PRE_W'(1);
        end
    end

    // ------------------------------------------------------------------
    // Buzzer: high on the entry cycle, toggles every BEEP_DIV cycles while
    // ringing, forced low with its counter cleared otherwise.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_buzzer   <= 1'b0;
            r_beep_cnt <= '0;
        end else if (w_next_state != c_S_RINGING) begin
            r_buzzer   <= 1'b0;
            r_beep_cnt <= '0;
        end else if (r_state != c_S_RINGING) begin
            r_buzzer   <= 1'b1;
            r_beep_cnt <= '0;
        end else if (r_beep_cnt == c_BEEP_LAST) begin
            r_buzzer   <= ~r_buzzer;
            r_beep_cnt <= '0;
        end else begin
            r_beep_cnt <= r_beep_cnt + c_BEEP_W'(1);
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign al_hour_tens  = r_al_hour_tens;
    assign al_hour_units = r_al_hour_units;
    assign al_min_tens   = r_al_min_tens;
    assign al_min_units  = r_al_min_units;
    assign editing       = (r_state == c_S_EDIT);
    assign ringing       = (r_state == c_S_RINGING);
    assign buzzer        = r_buzzer;
`ifdef ALARM_SNOOZE_EN
    assign armed_led     = (r_state == c_S_ARMED) || (r_state == c_S_SNOOZED);
`else
    assign armed_led     = (r_state == c_S_ARMED);
`endif

endmodule
`default_nettype wire

// File: tb/tb_alarm_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_alarm_controller
// Description : Self-checking bench for alarm_controller (CLK_FREQ=10,
//               BEEP_DIV=2, RING_SEC=3, SNOOZE_SEC=2). Table-driven alarm
//               editing vectors plus directed ring/stop/snooze/reset sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alarm_controller;

    logic       clk = 1'b0;
    logic       reset;
    logic [2:0] hour_tens;
    logic [3:0] hour_units;
    logic [2:0] min_tens;
    logic [3:0] min_units;
    logic       btn_edit, btn_hour, btn_min, btn_stop, btn_snooze, arm_sw;
    logic [2:0] al_hour_tens;
    logic [3:0] al_hour_units;
    logic [2:0] al_min_tens;
    logic [3:0] al_min_units;
    logic       editing, ringing, buzzer, armed_led;

    int n_pass  = 0;
    int n_total = 0;

    alarm_controller #(
        .CLK_FREQ   (10),
        .RING_SEC   (3),
        .SNOOZE_SEC (2),
        .BEEP_DIV   (2)
    ) u_dut (
        .clk           (clk),
        .reset         (reset),
        .hour_tens     (hour_tens),
        .hour_units    (hour_units),
        .min_tens      (min_tens),
        .min_units     (min_units),
        .btn_edit      (btn_edit),
        .btn_hour      (btn_hour),
        .btn_min       (btn_min),
        .btn_stop      (btn_stop),
        .btn_snooze    (btn_snooze),
        .arm_sw        (arm_sw),
        .al_hour_tens  (al_hour_tens),
        .al_hour_units (al_hour_units),
        .al_min_tens   (al_min_tens),
        .al_min_units  (al_min_units),
        .editing       (editing),
        .ringing       (ringing),
        .buzzer        (buzzer),
        .armed_led     (armed_led)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         nh;   // btn_hour-only pulses
        int         nm;   // btn_min-only pulses
        int         nb;   // cycles with both buttons
        logic [13:0] exp; // {hour_tens, hour_units, min_tens, min_units}
    } vec_t;

    vec_t tbl [14];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp)
            n_pass++;
        else
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic set_time(input int hh, input int mm);
        hour_tens  = 3'(hh / 10);
        hour_units = 4'(hh % 10);
        min_tens   = 3'(mm / 10);
        min_units  = 4'(mm % 10);
    endtask

    task automatic pulses(input int nh, input int nm, input int nb);
        for (int i = 0; i < nh; i++) begin btn_hour = 1'b1; step(); end
        btn_hour = 1'b0;
        for (int i = 0; i < nm; i++) begin btn_min = 1'b1; step(); end
        btn_min = 1'b0;
        for (int i = 0; i < nb; i++) begin btn_hour = 1'b1; btn_min = 1'b1; step(); end
        btn_hour = 1'b0;
        btn_min  = 1'b0;
    endtask

    task automatic press_edit();
        btn_edit = 1'b1; step(); btn_edit = 1'b0;
    endtask

    // Leave 07:30, return to it: produces a fresh match edge.
    task automatic retrigger();
        set_time(7, 31); step();
        set_time(7, 30); step();
    endtask

    function automatic logic [13:0] al_digits();
        return {al_hour_tens, al_hour_units, al_min_tens, al_min_units};
    endfunction

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected finish");
        $fatal(1, "timeout");
    end

    initial begin : stim
        logic seen;

        tbl[0]  = '{9,  0,  0, {3'd0, 4'd9, 3'd0, 4'd0}};
        tbl[1]  = '{1,  0,  0, {3'd1, 4'd0, 3'd0, 4'd0}};
        tbl[2]  = '{9,  0,  0, {3'd1, 4'd9, 3'd0, 4'd0}};
        tbl[3]  = '{1,  0,  0, {3'd2, 4'd0, 3'd0, 4'd0}};
        tbl[4]  = '{3,  0,  0, {3'd2, 4'd3, 3'd0, 4'd0}};
        tbl[5]  = '{1,  0,  0, {3'd0, 4'd0, 3'd0, 4'd0}};
        tbl[6]  = '{0,  9,  0, {3'd0, 4'd0, 3'd0, 4'd9}};
        tbl[7]  = '{0,  1,  0, {3'd0, 4'd0, 3'd1, 4'd0}};
        tbl[8]  = '{0,  49, 0, {3'd0, 4'd0, 3'd5, 4'd9}};
        tbl[9]  = '{0,  1,  0, {3'd0, 4'd0, 3'd0, 4'd0}};
        tbl[10] = '{0,  0,  1, {3'd0, 4'd1, 3'd0, 4'd1}};
        tbl[11] = '{23, 59, 0, {3'd0, 4'd0, 3'd0, 4'd0}};
        tbl[12] = '{24, 61, 0, {3'd0, 4'd0, 3'd0, 4'd1}};
        tbl[13] = '{10, 0,  0, {3'd1, 4'd0, 3'd0, 4'd1}};

        reset = 1'b0;
        {btn_edit, btn_hour, btn_min, btn_stop, btn_snooze, arm_sw} = '0;
        set_time(12, 34);
        step(); step();
        check("reset_status", {editing, ringing, buzzer, armed_led}, 4'b0000);
        check("reset_alarm", al_digits(), 14'd0);
        reset = 1'b1;

        // ---- editing table ----
        press_edit();
        check("enter_edit", editing, 1'b1);
        for (int i = 0; i < 14; i++) begin
            pulses(tbl[i].nh, tbl[i].nm, tbl[i].nb);
            check($sformatf("edit_vec%0d", i), al_digits(), tbl[i].exp);
        end
        arm_sw = 1'b1;
        press_edit();
        check("leave_edit_armed", {editing, armed_led}, 2'b01);

        // ---- set alarm 07:30 (from 10:01) ----
        press_edit();
        pulses(21, 29, 0);
        press_edit();
        check("alarm_0730", al_digits(), {3'd0, 4'd7, 3'd3, 4'd0});
        check("armed_0730", {editing, armed_led}, 2'b01);

        // ---- ring, beep pattern, auto-stop ----
        set_time(7, 29); step();
        check("no_ring_0729", ringing, 1'b0);
        set_time(7, 30); step();
        check("ring_start", {ringing, buzzer}, 2'b11);
        for (int k = 1; k < 30; k++) begin
            step();
            check($sformatf("ring_hold%0d", k), ringing, 1'b1);
            check($sformatf("beep%0d", k), buzzer, ((k / 2) % 2) == 0);
        end
        step();
        check("auto_stop", {ringing, buzzer, armed_led}, 3'b001);
        seen = 1'b0;
        for (int k = 0; k < 40; k++) begin step(); seen |= ringing; end
        check("no_rering_same_minute", seen, 1'b0);

        // ---- stop, no retrigger within minute, re-ring after leaving ----
        retrigger();
        check("ring_again", ringing, 1'b1);
        btn_edit = 1'b1; step(); btn_edit = 1'b0;
        check("edit_ignored_ringing", {ringing, editing}, 2'b10);
        btn_stop = 1'b1; step(); btn_stop = 1'b0;
        check("stop", {ringing, buzzer, armed_led}, 3'b001);
        seen = 1'b0;
        for (int k = 0; k < 10; k++) begin step(); seen |= ringing; end
        check("no_retrigger_after_stop", seen, 1'b0);
        retrigger();
        check("ring_after_minute_step", ringing, 1'b1);

`ifdef ALARM_SNOOZE_EN
        btn_snooze = 1'b1; step(); btn_snooze = 1'b0;
        check("snooze_enter", {ringing, buzzer, armed_led}, 3'b001);
        seen = 1'b0;
        for (int k = 1; k < 20; k++) begin step(); seen |= ringing; end
        check("snooze_quiet", seen, 1'b0);
        step();
        check("snooze_rering", {ringing, buzzer}, 2'b11);
        btn_stop = 1'b1; btn_snooze = 1'b1; step();
        btn_stop = 1'b0; btn_snooze = 1'b0;
        check("stop_beats_snooze", {ringing, armed_led}, 2'b01);
        seen = 1'b0;
        for (int k = 0; k < 25; k++) begin step(); seen |= ringing; end
        check("stop_beats_snooze_quiet", seen, 1'b0);
`else
        btn_snooze = 1'b1; step(); btn_snooze = 1'b0;
        check("snooze_as_stop", {ringing, buzzer, armed_led}, 3'b001);
        seen = 1'b0;
        for (int k = 0; k < 25; k++) begin step(); seen |= ringing; end
        check("snooze_as_stop_quiet", seen, 1'b0);
`endif

        // ---- disarm while ringing ----
        retrigger();
        check("ring_before_disarm", ringing, 1'b1);
        arm_sw = 1'b0; step();
        check("disarm_idle", {ringing, buzzer, armed_led}, 3'b000);

        // ---- reset mid-ring ----
        arm_sw = 1'b1; step();
        check("rearm", armed_led, 1'b1);
        retrigger();
        step(); step(); step();
        check("ring_before_reset", ringing, 1'b1);
        reset = 1'b0; step();
        check("reset_mid_ring_status", {editing, ringing, buzzer, armed_led}, 4'b0000);
        check("reset_mid_ring_alarm", al_digits(), 14'd0);
        step();
        check("reset_held_status", {editing, ringing, buzzer, armed_led}, 4'b0000);
        reset = 1'b1;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
